// File: rtl/alu_exec_stage_if.sv
// Request/response bundle for the ALU execute stage.
// The master side issues operations and the slave side returns result and flags.
interface alu_exec_stage_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       use_acc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] flags;

    modport master (
        output in_valid, op, a, b, use_acc, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op, a, b, use_acc, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Single-issue 8-bit ALU execute stage with an accumulator.
// It moves IDLE -> EXEC -> HOLD, and its outputs are registered and held until consumed.
module alu_exec_stage (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_stage_if.slave bus
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t     state;
    logic       live;
    logic [2:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] acc;
    logic [7:0] result_q;
    logic [3:0] flags_q;
    logic       out_valid_q;

    logic [8:0] au_sum;
    logic [7:0] au_res;
    logic       au_c;
    logic       au_v;
    logic [7:0] lu_res;
    logic [7:0] alu_res;
    logic [3:0] alu_flags;
    logic       accept;
    logic       consume;

    // live stays low through reset, so in_ready only rises on the first edge after release.
    assign bus.in_ready  = ((state == IDLE) && live) || ((state == HOLD) && bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign consume = out_valid_q && bus.out_ready;

    always_comb begin
        au_sum = 9'd0;
        au_c   = 1'b0;
        au_v   = 1'b0;
        case (op_q[1:0])
            2'b00: begin
                au_sum = {1'b0, a_q} + {1'b0, b_q};
                au_c   = au_sum[8];
                au_v   = (a_q[7] == b_q[7]) && (au_sum[7] != a_q[7]);
            end
            2'b01: begin
                au_sum = {1'b0, a_q} + 9'd1;
                au_c   = au_sum[8];
                au_v   = (a_q == 8'h7F);
            end
            // Carry is reported as borrow for subtract and decrement.
            2'b10: begin
                au_sum = {1'b0, a_q} + {1'b0, ~b_q} + 9'd1;
                au_c   = ~au_sum[8];
                au_v   = (a_q[7] != b_q[7]) && (au_sum[7] != a_q[7]);
            end
            default: begin
                au_sum = {1'b0, a_q} + 9'h0FF;
                au_c   = ~au_sum[8];
                au_v   = (a_q == 8'h80);
            end
        endcase
        au_res = au_sum[7:0];
    end

    always_comb begin
        lu_res = 8'h00;
        case (op_q[1:0])
            2'b00:   lu_res = a_q & b_q;
            2'b01:   lu_res = a_q | b_q;
            2'b10:   lu_res = a_q ^ b_q;
            default: lu_res = ~a_q;
        endcase
    end

    assign alu_res   = op_q[2] ? lu_res : au_res;
    assign alu_flags = {(alu_res == 8'h00), alu_res[7],
                        (~op_q[2] & au_c), (~op_q[2] & au_v)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            live        <= 1'b0;
            op_q        <= 3'd0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            acc         <= 8'h00;
            result_q    <= 8'h00;
            flags_q     <= 4'b0000;
            out_valid_q <= 1'b0;
        end else begin
            live <= 1'b1;
            // The accumulator is already updated when HOLD accepts a new request.
            if (accept) begin
                op_q <= bus.op;
                a_q  <= bus.use_acc ? acc : bus.a;
                b_q  <= bus.b;
            end
            case (state)
                IDLE: begin
                    if (accept) state <= EXEC;
                end
                EXEC: begin
                    result_q    <= alu_res;
                    flags_q     <= alu_flags;
                    acc         <= alu_res;
                    out_valid_q <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (consume) begin
                        out_valid_q <= 1'b0;
                        state       <= accept ? EXEC : IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed testbench for alu_exec_stage.
// Every expected value below is worked out by hand.
module tb_alu_exec_stage;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_INC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    alu_exec_stage_if bus ();

    alu_exec_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One full transaction: accept, one cycle in EXEC, result in HOLD, then consume.
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic use_acc,
                                 input logic [7:0] exp_res, input logic [3:0] exp_flags);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.use_acc   = use_acc;
        bus.out_ready = 1'b1;
        checkOutput({tag, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op       = ~op;
        bus.a        = ~a;
        bus.b        = ~b;
        bus.use_acc  = ~use_acc;
        checkOutput({tag, "_exec_valid"}, bus.out_valid, 0);
        checkOutput({tag, "_exec_ready"}, bus.in_ready, 0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_hold_valid"}, bus.out_valid, 1);
        checkOutput({tag, "_result"}, bus.result, exp_res);
        checkOutput({tag, "_flags"}, bus.flags, exp_flags);
        @(posedge clk);
        #1;
        checkOutput({tag, "_consumed"}, bus.out_valid, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.use_acc   = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_result", bus.result, 8'h00);
        checkOutput("rst_flags", bus.flags, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("release_in_ready_before_edge", bus.in_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("release_in_ready_after_edge", bus.in_ready, 1);

        applyStimulus("add_7f_01", OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0101);
        applyStimulus("sub_05_07", OP_SUB, 8'h05, 8'h07, 1'b0, 8'hFE, 4'b0110);
        applyStimulus("inc_ff",    OP_INC, 8'hFF, 8'h33, 1'b0, 8'h00, 4'b1010);
        applyStimulus("dec_00",    OP_DEC, 8'h00, 8'h33, 1'b0, 8'hFF, 4'b0110);
        applyStimulus("xor_aa_aa", OP_XOR, 8'hAA, 8'hAA, 1'b0, 8'h00, 4'b1000);
        applyStimulus("inc_7f",    OP_INC, 8'h7F, 8'hFF, 1'b0, 8'h80, 4'b0101);
        applyStimulus("dec_80",    OP_DEC, 8'h80, 8'h00, 1'b0, 8'h7F, 4'b0001);
        applyStimulus("sub_80_01", OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0001);
        applyStimulus("add_ff_01", OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1010);
        applyStimulus("and_f0_3c", OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000);
        applyStimulus("or_f0_0f",  OP_OR,  8'hF0, 8'h0F, 1'b0, 8'hFF, 4'b0100);

        applyStimulus("acc_add",   OP_ADD, 8'h10, 8'h20, 1'b0, 8'h30, 4'b0000);
        applyStimulus("acc_add2",  OP_ADD, 8'h99, 8'h05, 1'b1, 8'h35, 4'b0000);
        applyStimulus("acc_not",   OP_NOT, 8'h00, 8'h77, 1'b1, 8'hCA, 4'b0100);

        // Backpressure: the held result stays put, then consume and accept share an edge.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.op        = OP_ADD;
        bus.a         = 8'h01;
        bus.b         = 8'h02;
        bus.use_acc   = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.op      = OP_SUB;
        bus.a       = 8'hEE;
        bus.b       = 8'h04;
        bus.use_acc = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", bus.in_ready, 0);
            checkOutput("bp_out_valid", bus.out_valid, 1);
            checkOutput("bp_result", bus.result, 8'h03);
            checkOutput("bp_flags", bus.flags, 4'b0000);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp_release_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("bp_exec_valid", bus.out_valid, 0);
        checkOutput("bp_exec_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("bp_second_valid", bus.out_valid, 1);
        checkOutput("bp_second_result", bus.result, 8'hFF);
        checkOutput("bp_second_flags", bus.flags, 4'b0110);
        @(posedge clk);
        #1;
        checkOutput("bp_second_consumed", bus.out_valid, 0);

        // Reset while an add is in EXEC discards it and clears the accumulator.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = OP_ADD;
        bus.a        = 8'h40;
        bus.b        = 8'h40;
        bus.use_acc  = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", bus.out_valid, 0);
        checkOutput("mid_rst_result", bus.result, 8'h00);
        checkOutput("mid_rst_flags", bus.flags, 4'b0000);
        checkOutput("mid_rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("post_rst_no_valid", bus.out_valid, 0);
        end
        applyStimulus("post_rst_acc", OP_ADD, 8'hAB, 8'h05, 1'b1, 8'h05, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
